// File: rtl/mem_cmd_responder_pkg.sv
// Command codes, FSM states and default geometry shared by the responder
// and the verification FSM that drives it.
package mem_cmd_responder_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   localparam logic [7:0] CMD_READ  = 8'h00;
   localparam logic [7:0] CMD_WRITE = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_WAIT,
      S_RD_REQ,
      S_RD_DATA,
      S_TX_SEND,
      S_TX_GUARD,
      S_TX_WAIT
   } state_t;

   function automatic logic cmd_legal(input logic [7:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_WRITE);
   endfunction
endpackage

// File: rtl/mem_cmd_responder_byte_ram.sv
// Byte memory: synchronous write, registered read (data valid one cycle after address).
// Contents are deliberately not reset so test data survives a responder reset.
module mem_cmd_responder_byte_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_cmd_responder.sv
// Executes one read/write command over an inclusive address range between the UART and byte memory.
// Writes pace on rx_valid; reads emit tx_start three cycles after RD_REQ entry and pace on tx_busy.
module mem_cmd_responder
   import mem_cmd_responder_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   input  logic [7:0]        command_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W-1:0] end_addr_i,
   output logic              cmd_ready_o,
   input  logic              rx_valid_i,
   input  logic [DATA_W-1:0] rx_data_i,
   output logic              tx_start_o,
   output logic [DATA_W-1:0] tx_data_o,
   input  logic              tx_busy_i,
   output logic              rx_done_o,
   output logic              tx_done_o,
   output logic              err_o
);
   localparam int AW = $clog2(DEPTH);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] end_q;
   logic [DATA_W-1:0] tx_data_q;
   logic [DATA_W-1:0] ram_rdata;
   logic              tx_start_q;
   logic              rx_done_q;
   logic              tx_done_q;
   logic              err_q;
   logic              ram_we;
   logic              cmd_bad;

   assign addr_d  = addr_q + ADDR_W'(1);
   assign ram_we  = (state_q == S_WR_WAIT) && rx_valid_i;
   // Validating the range up front guarantees addr_q never runs past end_q or DEPTH.
   assign cmd_bad = (end_addr_i < start_addr_i) ||
                    (end_addr_i >= ADDR_W'(DEPTH)) ||
                    !cmd_legal(command_i);

   mem_cmd_responder_byte_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .addr_i  (addr_q[AW-1:0]),
      .wdata_i (rx_data_i),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         end_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         rx_done_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         rx_done_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  addr_q <= start_addr_i;
                  end_q  <= end_addr_i;
                  if (cmd_bad) begin
                     err_q <= 1'b1;
                  end else if (command_i == CMD_WRITE) begin
                     state_q <= S_WR_WAIT;
                  end else begin
                     state_q <= S_RD_REQ;
                  end
               end
            end
            S_WR_WAIT: begin
               if (rx_valid_i) begin
                  if (addr_q == end_q) begin
                     rx_done_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     addr_q <= addr_d;
                  end
               end
            end
            S_RD_REQ: state_q <= S_RD_DATA;
            S_RD_DATA: begin
               tx_data_q <= ram_rdata;
               state_q   <= S_TX_SEND;
            end
            S_TX_SEND: begin
               if (!tx_busy_i) begin
                  tx_start_q <= 1'b1;
                  state_q    <= S_TX_GUARD;
               end
            end
            // Transmitter raises busy one cycle late; skip sampling it here.
            S_TX_GUARD: state_q <= S_TX_WAIT;
            S_TX_WAIT: begin
               if (!tx_busy_i) begin
                  if (addr_q == end_q) begin
                     tx_done_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     addr_q  <= addr_d;
                     state_q <= S_RD_REQ;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign tx_start_o  = tx_start_q;
   assign tx_data_o   = tx_data_q;
   assign rx_done_o   = rx_done_q;
   assign tx_done_o   = tx_done_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed plus randomized bench for mem_cmd_responder against a byte-array reference model.
module tb_mem_cmd_responder;
   import mem_cmd_responder_pkg::*;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  command = 8'h00;
   logic [15:0] start_addr = '0;
   logic [15:0] end_addr = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_busy = 1'b0;
   logic        cmd_ready, tx_start, rx_done, tx_done, err;
   logic [7:0]  tx_data;

   always #5 clk = ~clk;

   mem_cmd_responder dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .command_i    (command),
      .start_addr_i (start_addr),
      .end_addr_i   (end_addr),
      .cmd_ready_o  (cmd_ready),
      .rx_valid_i   (rx_valid),
      .rx_data_i    (rx_data),
      .tx_start_o   (tx_start),
      .tx_data_o    (tx_data),
      .tx_busy_i    (tx_busy),
      .rx_done_o    (rx_done),
      .tx_done_o    (tx_done),
      .err_o        (err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] model_mem [DEPTH];

   always @(posedge clk) cyc <= cyc + 1;

   // UART transmitter model: busy rises the cycle after tx_start and lasts busy_len cycles.
   int busy_len = 10;
   int busy_cnt = 0;
   bit busy_pend = 1'b0;
   always @(negedge clk) begin
      if (busy_pend) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      busy_pend = (tx_start === 1'b1);
      tx_busy = (busy_cnt > 0);
   end

   int n_txs = 0, n_rxd = 0, n_txd = 0, n_err = 0;
   int rxd_cyc = 0, txd_cyc = 0, err_cyc = 0;
   logic [7:0] tx_log [$];
   int         txs_cyc_log [$];
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         n_txs++;
         tx_log.push_back(tx_data);
         txs_cyc_log.push_back(cyc);
      end
      if (rx_done === 1'b1) begin n_rxd++; rxd_cyc = cyc; end
      if (tx_done === 1'b1) begin n_txd++; txd_cyc = cyc; end
      if (err === 1'b1)     begin n_err++; err_cyc = cyc; end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue_cmd(input logic [7:0] c, input int s, input int e, output int acc);
      @(negedge clk);
      command = c; start_addr = 16'(s); end_addr = 16'(e); cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b, output int c);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = b;
      @(negedge clk);
      rx_valid = 1'b0;
      c = cyc;
   endtask

   task automatic do_write(input int s, input int e, input bit seq, input logic [7:0] base,
                           input bit inject);
      int acc, acc2, c, rx0, e0;
      logic [7:0] b;
      rx0 = n_rxd; e0 = n_err; c = 0;
      issue_cmd(CMD_WRITE, s, e, acc);
      for (int a = s; a <= e; a++) begin
         b = seq ? base + 8'(a - s) : 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(b, c);
         model_mem[a] = b;
         if (a < e) chk("wr_no_early_done", n_rxd - rx0, 0);
         if (inject && a == s) begin
            issue_cmd(CMD_READ, 0, 0, acc2);
            chk("wr_busy_ready", {31'd0, cmd_ready}, (s == e) ? 1 : 0);
         end
      end
      @(negedge clk);
      chk("wr_done_cnt", n_rxd - rx0, 1);
      chk("wr_done_cyc", rxd_cyc, c);
      chk("wr_no_err", n_err - e0, 0);
      chk("wr_idle_ready", {31'd0, cmd_ready}, 1);
   endtask

   task automatic do_read(input int s, input int e);
      int acc, t0, d0, base, n, last;
      bit seen;
      n = e - s + 1;
      for (int k = 0; k < 200 && tx_busy; k++) @(negedge clk);
      t0 = n_txs; d0 = n_txd; base = tx_log.size();
      issue_cmd(CMD_READ, s, e, acc);
      seen = 1'b0;
      for (int k = 0; k < n * (busy_len + 12) + 40; k++) begin
         @(negedge clk);
         if (n_txd > d0) begin seen = 1'b1; break; end
      end
      chk("rd_timeout", {31'd0, seen}, 1);
      chk("rd_start_cnt", n_txs - t0, n);
      chk("rd_first_start", (txs_cyc_log.size() > base) ? txs_cyc_log[base] - acc : -1, 3);
      for (int i = 0; i < n; i++)
         chk("rd_byte", (tx_log.size() > base + i) ? {24'd0, tx_log[base + i]} : 32'hxxxx_xxxx,
             {24'd0, model_mem[s + i]});
      last = (txs_cyc_log.size() > 0) ? txs_cyc_log[txs_cyc_log.size() - 1] : 0;
      chk("rd_done_cyc", txd_cyc, last + busy_len + 2);
      repeat (3) @(negedge clk);
      chk("rd_done_cnt", n_txd - d0, 1);
   endtask

   task automatic reject(input logic [7:0] c, input int s, input int e);
      int acc, e0, r0, d0;
      e0 = n_err; r0 = n_rxd; d0 = n_txd;
      issue_cmd(c, s, e, acc);
      chk("rej_ready_next", {31'd0, cmd_ready}, 1);
      @(negedge clk);
      chk("rej_err_cnt", n_err - e0, 1);
      chk("rej_err_cyc", err_cyc, acc);
      chk("rej_no_done", (n_rxd - r0) + (n_txd - d0), 0);
   endtask

   initial begin
      int acc, t0, d0, c, s, e;
      bit seen;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("rst_tx_start", {31'd0, tx_start}, 0);
      chk("rst_strobes", {29'd0, rx_done, tx_done, err}, 0);
      chk("rst_tx_data", {24'd0, tx_data}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1/2: sequential fill of the input half, then read back with 10-cycle busy
      busy_len = 10;
      do_write(8, 15, 1'b1, 8'hA0, 1'b0);
      do_read(8, 15);

      // 3: single-byte range
      busy_len = 4;
      model_mem[3] = 8'h5A;
      issue_cmd(CMD_WRITE, 3, 3, acc);
      send_byte(8'h5A, c);
      @(negedge clk);
      chk("single_wr_done_cyc", rxd_cyc, c);
      do_read(3, 3);

      // 4: illegal command, inverted range, out-of-range end
      reject(8'h02, 0, 1);
      reject(CMD_READ, 5, 2);
      reject(CMD_WRITE, 8, 16);
      reject(CMD_READ, 0, 16'hFFFF);

      // 5: reset after third tx_start of a read
      busy_len = 10;
      for (int k = 0; k < 200 && tx_busy; k++) @(negedge clk);
      t0 = n_txs; d0 = n_txd;
      issue_cmd(CMD_READ, 8, 15, acc);
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (n_txs - t0 >= 3) begin seen = 1'b1; break; end
      end
      chk("rst5_third_start", {31'd0, seen}, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst5_ready", {31'd0, cmd_ready}, 1);
      chk("rst5_tx_start", {31'd0, tx_start}, 0);
      repeat (40) @(negedge clk);
      chk("rst5_no_done", n_txd - d0, 0);
      chk("rst5_starts", n_txs - t0, 3);
      do_read(8, 15);

      // 6: stray rx byte in IDLE, read command during WR_WAIT
      send_byte(8'hEE, c);
      do_write(0, 3, 1'b0, 8'h00, 1'b1);
      busy_len = 3;
      do_read(0, 3);
      do_read(8, 15);

      // randomized ranges, data and transmitter pacing
      for (int it = 0; it < 6; it++) begin
         s = $urandom_range(0, DEPTH - 1);
         e = $urandom_range(s, DEPTH - 1);
         busy_len = $urandom_range(1, 12);
         do_write(s, e, 1'b0, 8'h00, 1'b0);
         do_read(s, e);
      end
      do_read(0, DEPTH - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
